mini_src_alu_sequencer: RTL and testbench

Control sequencer that drives the Phase 1 datapath's control inputs for register-to-register ALU instructions. It replaces the hand-written per-instruction state machines in the benches. On `start` it runs the full fetch/decode/execute sequence: it fetches through PC/MAR/MDR, decodes IR, and issues the one-hot register, ALU and HI/LO strobes. It sits directly upstream of `datapath`, and all of its outputs connect one-to-one to datapath control inputs.

---
 rtl/mini_src_pkg.sv | 92 +++++++++
 rtl/reg_select_decoder.sv | 24 ++
 rtl/mini_src_alu_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mini_src_alu_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mini_src_pkg
// Purpose  : Shared definitions for the mini SRC control sequencer: opcode
//            values, alu_op encoding, sequencer state encoding, IR field bit
//            positions and small opcode classification helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mini_src_pkg;

  // IR field bit positions
  localparam int IR_OP_LSB = 27;   // opcode = IR[31:27]
  localparam int IR_RA_LSB = 23;   // Ra     = IR[26:23] (destination)
  localparam int IR_RB_LSB = 19;   // Rb     = IR[22:19] (source 1)
  localparam int IR_RC_LSB = 15;   // Rc     = IR[18:15] (source 2)

  // Opcodes
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;

  // alu_op encoding (0 = no operation, then opcode order)
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHRA = 4'd6;
  localparam logic [3:0] ALU_SHL  = 4'd7;
  localparam logic [3:0] ALU_ROR  = 4'd8;
  localparam logic [3:0] ALU_ROL  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;
  localparam logic [3:0] ALU_NEG  = 4'd12;
  localparam logic [3:0] ALU_NOT  = 4'd13;

  // Sequencer states
  localparam int         STATE_W = 3;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_T0    = 3'd1;
  localparam logic [2:0] S_T1    = 3'd2;
  localparam logic [2:0] S_T2    = 3'd3;
  localparam logic [2:0] S_T3    = 3'd4;
  localparam logic [2:0] S_T4    = 3'd5;
  localparam logic [2:0] S_T5    = 3'd6;
  localparam logic [2:0] S_T6    = 3'd7;

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SHR:  return ALU_SHR;
      OP_SHRA: return ALU_SHRA;
      OP_SHL:  return ALU_SHL;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      OP_NEG:  return ALU_NEG;
      OP_NOT:  return ALU_NOT;
      default: return ALU_NONE;
    endcase
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return (op <= OP_NOT);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_select_decoder.sv
`default_nettype none
// ============================================================================
// Module   : reg_select_decoder
// Purpose  : Register-select decoder, SELW-bit index to 2**SELW one-hot
//            strobes, all zero when en is low.
// Ports    : en     in  1             decoder enable
//            sel    in  SELW          register index
//            onehot out 2**SELW       one-hot strobe vector
// Revision : 1.0 - initial release
// ============================================================================
module reg_select_decoder #(
  parameter int SELW = 4
) (
  input  logic                 en,
  input  logic [SELW-1:0]      sel,
  output logic [(1<<SELW)-1:0] onehot
);

  for (genvar i = 0; i < (1 << SELW); i++) begin : g_onehot
    assign onehot[i] = en && (sel == SELW'(i));
  end

endmodule
`default_nettype wire

// File: rtl/mini_src_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mini_src_alu_sequencer
// Purpose  : Fetch/decode/execute control sequencer for register-to-register
//            ALU instructions. Drives datapath control strobes one-to-one.
// Ports    : clock  in   1   system clock, rising edge
//            clear  in   1   asynchronous active-low reset
//            start  in   1   begin one instruction (sampled in IDLE only)
//            ir     in   32  datapath IR output (not latched here)
//            Rin    out  16  one-hot register load strobes
//            Rout   out  16  one-hot register bus-drive strobes
//            PCout..LOin out 1 datapath strobes
//            alu_op out  4   ALU operation code
//            busy   out  1   high outside IDLE
//            done   out  1   final-state pulse of a legal instruction
//            illegal out 1   pulse on an undefined opcode
// Revision : 1.0 - initial release
// ============================================================================
module mini_src_alu_sequencer
  import mini_src_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int REGW = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [31:0]        ir,
  output logic [(1<<REGW)-1:0] Rin,
  output logic [(1<<REGW)-1:0] Rout,
  output logic               PCout,
  output logic               MARin,
  output logic               IncPC,
  output logic               Zin,
  output logic               Zlowout,
  output logic               Zhighout,
  output logic               PCin,
  output logic               Read,
  output logic               MDRin,
  output logic               MDRout,
  output logic               IRin,
  output logic               Yin,
  output logic               HIin,
  output logic               LOin,
  output logic [3:0]         alu_op,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;

  logic [OPW-1:0]  w_opcode;
  logic [REGW-1:0] w_ra;
  logic [REGW-1:0] w_rb;
  logic [REGW-1:0] w_rc;
  logic            w_unused_ir;

  logic            w_rin_en;
  logic            w_rout_en;
  logic [REGW-1:0] w_rin_sel;
  logic [REGW-1:0] w_rout_sel;

  assign w_opcode    = ir[IR_OP_LSB +: OPW];
  assign w_ra        = ir[IR_RA_LSB +: REGW];
  assign w_rb        = ir[IR_RB_LSB +: REGW];
  assign w_rc        = ir[IR_RC_LSB +: REGW];
  assign w_unused_ir = ^ir[IR_RC_LSB-1:0];

  // State register; clear drops straight to IDLE, which zeroes every output.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state: fetch is common, execute length depends on opcode class.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = start ? S_T0 : S_IDLE;
      S_T0:   w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_T2:   w_next = S_T3;
      S_T3:   w_next = is_legal(w_opcode) ? S_T4 : S_IDLE;
      S_T4:   w_next = is_unary(w_opcode) ? S_IDLE : S_T5;
      S_T5:   w_next = is_muldiv(w_opcode) ? S_T6 : S_IDLE;
      S_T6:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs from state plus the (externally held) IR fields.
  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0;
    Zlowout = 1'b0; Zhighout = 1'b0; PCin = 1'b0; Read = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    HIin = 1'b0; LOin = 1'b0;
    alu_op = ALU_NONE; done = 1'b0; illegal = 1'b0;
    w_rin_en = 1'b0; w_rin_sel = w_ra;
    w_rout_en = 1'b0; w_rout_sel = w_rb;
    case (r_state)
      S_T0: begin
        // alu_op stays NONE: the datapath's IncPC path forms PC+1.
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        if (!is_legal(w_opcode)) begin
          illegal = 1'b1;
        end else if (is_unary(w_opcode)) begin
          w_rout_en = 1'b1; alu_op = alu_code(w_opcode); Zin = 1'b1;
        end else begin
          w_rout_en = 1'b1; Yin = 1'b1;
        end
      end
      S_T4: begin
        if (is_unary(w_opcode)) begin
          Zlowout = 1'b1; w_rin_en = 1'b1; done = 1'b1;
        end else begin
          w_rout_en = 1'b1; w_rout_sel = w_rc;
          alu_op = alu_code(w_opcode); Zin = 1'b1;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv(w_opcode)) begin
          LOin = 1'b1;
        end else begin
          w_rin_en = 1'b1; done = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  reg_select_decoder #(.SELW(REGW)) u_rin_dec (
    .en     (w_rin_en),
    .sel    (w_rin_sel),
    .onehot (Rin)
  );

  reg_select_decoder #(.SELW(REGW)) u_rout_dec (
    .en     (w_rout_en),
    .sel    (w_rout_sel),
    .onehot (Rout)
  );

endmodule
`default_nettype wire

// File: tb/tb_mini_src_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mini_src_alu_sequencer
// Purpose  : Scoreboard bench for mini_src_alu_sequencer. The stimulus side
//            pushes the expected per-cycle strobe pattern of each instruction;
//            a monitor pops one entry per busy cycle and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mini_src_alu_sequencer;

  typedef logic [51:0] vec_t;  // {Rin, Rout, strobes[13:0], alu_op, done, illegal}

  localparam logic [13:0] C_PCOUT  = 14'h2000;
  localparam logic [13:0] C_MARIN  = 14'h1000;
  localparam logic [13:0] C_INCPC  = 14'h0800;
  localparam logic [13:0] C_ZIN    = 14'h0400;
  localparam logic [13:0] C_ZLOW   = 14'h0200;
  localparam logic [13:0] C_ZHIGH  = 14'h0100;
  localparam logic [13:0] C_PCIN   = 14'h0080;
  localparam logic [13:0] C_READ   = 14'h0040;
  localparam logic [13:0] C_MDRIN  = 14'h0020;
  localparam logic [13:0] C_MDROUT = 14'h0010;
  localparam logic [13:0] C_IRIN   = 14'h0008;
  localparam logic [13:0] C_YIN    = 14'h0004;
  localparam logic [13:0] C_HIIN   = 14'h0002;
  localparam logic [13:0] C_LOIN   = 14'h0001;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir    = 32'h0;
  logic [15:0] Rin, Rout;
  logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
  logic        MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [3:0]  alu_op;
  logic        busy, done, illegal;

  int   n_total = 0;
  int   n_pass  = 0;
  vec_t sb[$];

  always #5 clock = ~clock;

  mini_src_alu_sequencer #(.OPW(5), .REGW(4)) dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir),
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
  );

  function automatic vec_t actual();
    return {Rin, Rout,
            {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read,
             MDRin, MDRout, IRin, Yin, HIin, LOin},
            alu_op, done, illegal};
  endfunction

  function automatic vec_t mk(input logic [15:0] rin, input logic [15:0] rout,
                              input logic [13:0] s, input logic [3:0] alu,
                              input logic dn, input logic il);
    return {rin, rout, s, alu, dn, il};
  endfunction

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the cycle-by-cycle strobe list of one instruction.
  task automatic push_expected(input logic [31:0] iv);
    int          op;
    logic [15:0] ra1, rb1, rc1;
    logic [3:0]  code;
    op   = int'(iv[31:27]);
    ra1  = 16'(1) << iv[26:23];
    rb1  = 16'(1) << iv[22:19];
    rc1  = 16'(1) << iv[18:15];
    code = 4'(op + 1);
    sb.push_back(mk(0, 0, C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 0, 0, 0));
    sb.push_back(mk(0, 0, C_ZLOW | C_PCIN | C_READ | C_MDRIN, 0, 0, 0));
    sb.push_back(mk(0, 0, C_MDROUT | C_IRIN, 0, 0, 0));
    if (op <= 8) begin
      sb.push_back(mk(0, rb1, C_YIN, 0, 0, 0));
      sb.push_back(mk(0, rc1, C_ZIN, code, 0, 0));
      sb.push_back(mk(ra1, 0, C_ZLOW, 0, 1, 0));
    end else if (op == 9 || op == 10) begin
      sb.push_back(mk(0, rb1, C_YIN, 0, 0, 0));
      sb.push_back(mk(0, rc1, C_ZIN, code, 0, 0));
      sb.push_back(mk(0, 0, C_ZLOW | C_LOIN, 0, 0, 0));
      sb.push_back(mk(0, 0, C_ZHIGH | C_HIIN, 0, 1, 0));
    end else if (op == 11 || op == 12) begin
      sb.push_back(mk(0, rb1, C_ZIN, code, 0, 0));
      sb.push_back(mk(ra1, 0, C_ZLOW, 0, 1, 0));
    end else begin
      sb.push_back(mk(0, 0, 0, 0, 0, 1));
    end
  endtask

  // Monitor: one scoreboard entry per busy cycle; idle cycles must be silent.
  always @(negedge clock) begin
    if (busy) begin
      if (sb.size() == 0) begin
        check("unexpected_busy", actual(), '0);
        n_total++;
        $display("FAIL busy_without_instruction: busy=1 expected 0 at %0t", $time);
      end else begin
        check("cycle_strobes", actual(), sb.pop_front());
      end
    end else begin
      check("idle_outputs", actual(), '0);
    end
  end

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (!busy) begin ok = 1'b1; break; end
    end
    n_total++;
    if (ok) n_pass++;
    else begin
      $display("FAIL %s_timeout: busy still 1 expected 0", name);
      sb.delete();
    end
  endtask

  task automatic run_one(input logic [31:0] iv, input string name);
    ir = iv;
    push_expected(iv);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_idle(name);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1 check("reset_outputs", {actual(), 11'd0, busy}, '0);
    clear = 1'b1;

    run_one(32'h2B820000, "shra");
    run_one(32'h012B0000, "add");
    run_one(32'h48188000, "mul");
    run_one(32'hF8000000, "illegal");
    run_one(32'h5B000000, "neg");   // NEG R6,R0
    run_one(32'h50000000, "div");

    // start pulse while busy must be ignored
    ir = 32'h0D1B8000;
    push_expected(ir);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(posedge clock); @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_idle("busy_start");
    repeat (3) @(negedge clock);

    // Back-to-back with start held high: exactly one IDLE cycle between.
    ir = 32'h012B0000;
    push_expected(32'h012B0000);
    push_expected(32'h09988000);
    @(posedge clock); #1 start = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clock);
        if (done) begin seen = 1'b1; break; end
      end
      check("b2b_first_done", {51'd0, seen}, 52'd1);
    end
    @(posedge clock); #1 ir = 32'h09988000;
    check("b2b_gap_idle", {51'd0, busy}, 52'd0);
    @(posedge clock); #1 start = 1'b0;
    check("b2b_second_t0", {51'd0, busy}, 52'd1);
    wait_idle("b2b_second");

    // Asynchronous clear in the middle of T4
    ir = 32'h012B0000;
    push_expected(ir);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #3 clear = 1'b0;
    sb.delete();
    #1 check("clear_mid_t4", {actual(), 11'd0, busy}, '0);
    @(posedge clock); #1 clear = 1'b1;
    @(negedge clock);
    check("after_clear_idle", {51'd0, busy}, 52'd0);

    // Randomized instructions, mostly legal with some illegal opcodes
    for (int n = 0; n < 40; n++) begin
      logic [31:0] r;
      logic [4:0]  op;
      r  = $urandom();
      op = 5'($urandom_range(0, 13));
      if ($urandom_range(0, 5) == 0) op = 5'($urandom_range(13, 31));
      run_one({op, r[26:0]}, "random");
    end

    repeat (2) @(negedge clock);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
